// File: rtl/pwm_multi.sv
// pwm_multi: N_CH PWM outputs driven from one shared counter.
// The counter is edge-aligned (0..MAX, wrap) or center-aligned (0..MAX..1).
// Duty values are written to shadow registers and copied into the active
// compare registers only on the period boundary edge, so a write can never
// glitch the period that is already running. The mode is latched on the same
// edge, which means every period starts at 0 and counts up.
module pwm_multi #(
  parameter int N_CH   = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   ch_inv,
  output logic [N_CH-1:0]   pwm_out,
  output logic              period_start,
  output logic [N_CH-1:0]   upd_pending
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic             mode_act_q, mode_act_d;
  logic [WIDTH-1:0] duty_sh_q  [N_CH];
  logic [WIDTH-1:0] duty_sh_d  [N_CH];
  logic [WIDTH-1:0] duty_act_q [N_CH];
  logic [WIDTH-1:0] duty_act_d [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             boundary;

  // Next-state: counter sequencing, boundary reload, shadow writes and compare.
  always_comb begin
    cnt_d      = cnt_q;
    dir_up_d   = dir_up_q;
    mode_act_d = mode_act_q;
    duty_sh_d  = duty_sh_q;
    duty_act_d = duty_act_q;
    pend_d     = pend_q;
    pwm_d      = '0;
    ps_d       = (cnt_q == '0);

    // Last value of a period: MAX in edge mode, 1 on the way down in center mode.
    boundary = mode_act_q ? (!dir_up_q && (cnt_q == ONE)) : (cnt_q == MAX);

    if (boundary) begin
      cnt_d      = '0;
      dir_up_d   = 1'b1;
      mode_act_d = mode;
      duty_act_d = duty_sh_q;
      pend_d     = '0;
    end else if (!mode_act_q) begin
      cnt_d = cnt_q + ONE;
    end else if (dir_up_q) begin
      if (cnt_q == MAX) begin
        cnt_d    = MAX - ONE;
        dir_up_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end

    // Addresses >= N_CH match no channel and are dropped. A write on the
    // boundary edge overrides the pending clear so it loads next period.
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        duty_sh_d[i] = wr_data;
        pend_d[i]    = 1'b1;
      end
    end

    // Compare uses the active duty of the current cycle; output is registered.
    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i] = (ch_en[i] && (cnt_q < duty_act_q[i])) ^ ch_inv[i];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      dir_up_q   <= 1'b1;
      mode_act_q <= 1'b0;
      pend_q     <= '0;
      pwm_q      <= '0;
      ps_q       <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      dir_up_q   <= dir_up_d;
      mode_act_q <= mode_act_d;
      pend_q     <= pend_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign upd_pending  = pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi with N_CH=2, WIDTH=4. A reference model tracks the
// position inside the current period and derives the counter value from it
// arithmetically; every cycle the DUT outputs are compared against it, and
// directed scenarios add duty-cycle and period-length counts.
module tb_pwm_multi;

  localparam int N_CH   = 2;
  localparam int WIDTH  = 4;
  localparam int ADDR_W = 2;
  localparam int MAX    = (1 << WIDTH) - 1;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              mode;
  logic [N_CH-1:0]   ch_en;
  logic [N_CH-1:0]   ch_inv;
  logic [N_CH-1:0]   pwm_out;
  logic              period_start;
  logic [N_CH-1:0]   upd_pending;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int       m_p    = 0;
  bit       m_mode = 0;
  int       m_sh  [N_CH];
  int       m_act [N_CH];
  bit [1:0] m_pend = '0;
  bit [1:0] e_pwm  = '0;
  bit       e_ps   = 0;

  pwm_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mode         (mode),
    .ch_en        (ch_en),
    .ch_inv       (ch_inv),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .upd_pending  (upd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cnt_of(int p, bit md);
    if (md && p > MAX) return 2 * MAX - p;
    return p;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int c, plen;
    if (rst) begin
      m_p = 0; m_mode = 0; m_pend = '0; e_pwm = '0; e_ps = 0;
      for (int i = 0; i < N_CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      return;
    end
    c = cnt_of(m_p, m_mode);
    for (int i = 0; i < N_CH; i++)
      e_pwm[i] = (ch_en[i] && (c < m_act[i])) ^ ch_inv[i];
    e_ps = (c == 0);
    plen = m_mode ? 2 * MAX : MAX + 1;
    if (m_p == plen - 1) begin
      for (int i = 0; i < N_CH; i++) m_act[i] = m_sh[i];
      m_pend = '0;
      m_mode = mode;
      m_p    = 0;
    end else begin
      m_p++;
    end
    if (wr_en && int'(wr_addr) < N_CH) begin
      m_sh[wr_addr] = int'(wr_data);
      m_pend[wr_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("pwm_out", 32'(pwm_out), 32'(e_pwm));
    check_val("period_start", 32'(period_start), 32'(e_ps));
    check_val("upd_pending", 32'(upd_pending), 32'(m_pend));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = WIDTH'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic count_win(input int n, output int h0, output int h1, output int nps);
    h0 = 0; h1 = 0; nps = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      h0  += int'(pwm_out[0]);
      h1  += int'(pwm_out[1]);
      nps += int'(period_start);
    end
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 40 && m_p != p; i++) tick();
    check_val("reach_pos", 32'(m_p), 32'(p));
  endtask

  initial begin
    int h0, h1, nps, k;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    mode = 1'b0; ch_en = '0; ch_inv = '0;
    ticks(2);
    check_val("rst_pwm", 32'(pwm_out), 32'h0);
    check_val("rst_pend", 32'(upd_pending), 32'h0);
    check_val("rst_ps", 32'(period_start), 32'h0);

    // edge mode, ch0 D=4: first period low, then 4 of 16
    rst = 1'b0; ch_en = 2'b11; ch_inv = 2'b00;
    write(0, 4);
    check_val("first_ps", 32'(period_start), 32'h1);
    check_val("pend_after_wr", 32'(upd_pending[0]), 32'h1);
    count_win(15, h0, h1, nps);
    check_val("first_period_ch0", 32'(h0), 32'd0);
    count_win(16, h0, h1, nps);
    check_val("edge_d4_high", 32'(h0), 32'd4);
    check_val("edge_ch1_low", 32'(h1), 32'd0);
    check_val("edge_ps_count", 32'(nps), 32'd1);

    // center mode D=4: 7 of 30, one period_start per 30
    mode = 1'b1;
    ticks(40);
    count_win(30, h0, h1, nps);
    check_val("center_d4_high", 32'(h0), 32'd7);
    check_val("center_ps_count", 32'(nps), 32'd1);

    // edge D=15 and D=0, with and without inversion
    mode = 1'b0;
    write(0, 15);
    ticks(70);
    count_win(16, h0, h1, nps);
    check_val("edge_d15_high", 32'(h0), 32'd15);
    ch_inv = 2'b01;
    ticks(2);
    count_win(16, h0, h1, nps);
    check_val("edge_d15_inv_high", 32'(h0), 32'd1);
    write(0, 0);
    ticks(40);
    count_win(16, h0, h1, nps);
    check_val("edge_d0_inv_high", 32'(h0), 32'd16);
    ch_inv = 2'b00;
    count_win(16, h0, h1, nps);
    check_val("edge_d0_high", 32'(h0), 32'd0);

    // write on the exact boundary edge
    write(0, 2);
    ticks(40);
    wait_pos(MAX);
    write(0, 8);
    check_val("bnd_pend_kept", 32'(upd_pending[0]), 32'h1);
    count_win(16, h0, h1, nps);
    check_val("bnd_old_duty", 32'(h0), 32'd2);
    count_win(16, h0, h1, nps);
    check_val("bnd_new_duty", 32'(h0), 32'd8);
    check_val("bnd_pend_clear", 32'(upd_pending), 32'h0);

    // mode toggled mid-period: current period finishes first
    wait_pos(5);
    mode = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!period_start && k < 40);
    check_val("mode_switch_delay", 32'(k), 32'd12);
    k = 0;
    do begin tick(); k++; end while (!period_start && k < 40);
    check_val("center_period_len", 32'(k), 32'd30);
    mode = 1'b0;

    // out-of-range write changes nothing
    write(3, 9);
    check_val("oor_pend", 32'(upd_pending), 32'h0);
    ticks(20);

    // reset mid-period with a pending write
    ch_inv = 2'b11;
    write(1, 5);
    rst = 1'b1;
    tick();
    check_val("midrst_pwm", 32'(pwm_out), 32'h0);
    check_val("midrst_pend", 32'(upd_pending), 32'h0);
    rst = 1'b0;
    tick();
    check_val("restart_ps", 32'(period_start), 32'h1);
    check_val("restart_pwm_inv", 32'(pwm_out), 32'h3);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_addr = ADDR_W'($urandom % 4);
      wr_data = WIDTH'($urandom % 16);
      if (($urandom % 8) == 0) ch_en = N_CH'($urandom);
      if (($urandom % 8) == 0) ch_inv = N_CH'($urandom);
      if (($urandom % 64) == 0) mode = ~mode;
      rst = ($urandom % 500) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised successor to the single-channel 8-bit PWM generator in the toi2s top level. It drives `N_CH` PWM outputs from one shared counter and supports edge-aligned or center-aligned modes. Each channel has a per-channel enable and polarity. Duty values are double-buffered so that updates take effect only at a period boundary, avoiding glitches. It sits beside the register bank, which writes duty values through a simple write strobe port, and feeds the pad-level PWM outputs.

## Interface
Parameters:
- `N_CH`, 4, number of PWM channels (1..16)
- `WIDTH`, 8, counter and duty width in bits (3..16); `MAX` = 2^WIDTH-1
- `ADDR_W`, 4, write-address width; must satisfy 2^ADDR_W >= N_CH

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `reset`  in  1  synchronous reset, active-high
- `wr_en`  in  1  write strobe for a duty shadow register
- `wr_addr`  in  ADDR_W  channel index; values >= N_CH are ignored
- `wr_data`  in  WIDTH  new duty value
- `mode`  in  1  0 = edge-aligned, 1 = center-aligned; sampled at the period boundary
- `ch_en`  in  N_CH  per-channel enable; takes effect immediately
- `ch_inv`  in  N_CH  per-channel output inversion; takes effect immediately
- `pwm_out`  out  N_CH  registered PWM outputs
- `period_start`  out  1  registered, high for the one cycle in which `cnt`==0
- `upd_pending`  out  N_CH  shadow written but not yet loaded into the active register

## Operation
- State: shared counter `cnt[WIDTH-1:0]`, direction bit `dir_up`, latched `mode_act`, and per channel `duty_sh` (shadow) and `duty_act` (active).
- Edge mode: `cnt` runs 0,1,…,MAX, then wraps to 0. Period = 2^WIDTH cycles. Last value of the period is MAX.
- Center mode: `cnt` runs 0 up to MAX, then MAX-1 down to 1, then back to 0. Period = 2·MAX cycles. `dir_up` clears after MAX and sets again at 0. Last value of the period is 1 while counting down.
- Boundary edge: the clock edge on which `cnt` leaves the last value of its period. On this edge, for every channel, `duty_act <= duty_sh`, `upd_pending` clears, `mode_act <= mode`, `cnt <= 0` and `dir_up <= 1`.
- A mode change therefore always starts a clean period at 0, counting up.
- Compare, per channel i: `raw = ch_en[i] & (cnt < duty_act[i])`. Then `pwm_out[i] <= raw ^ ch_inv[i]`.
- Duty behaviour: D=0 gives always low (before inversion). Edge mode is high for D cycles per period, so 100% duty is not reachable. Center mode is high for 2·D-1 cycles per period when 1<=D<=MAX.
- Disabled channel (`ch_en`=0): output equals `ch_inv[i]`. Shadow and active registers keep updating.
- Write: when `wr_en` is high and `wr_addr` < N_CH, `duty_sh[wr_addr] <= wr_data` and `upd_pending[wr_addr] <= 1`. Out-of-range writes change nothing.
- Write on the boundary edge: `duty_act` loads the previous shadow value. The new value lands in the shadow and `upd_pending` stays 1, so it loads at the next boundary.
- Multiple writes within one period: the last write wins.

## Timing
- Reset (`reset`=1 at an edge) sets: `cnt`=0, `dir_up`=1, `mode_act`=0, all `duty_sh`/`duty_act`=0, `upd_pending`=0, `pwm_out`=0, `period_start`=0.
- `pwm_out` reflects `ch_inv` from the first edge after reset is released.
- Reset asserted mid-period aborts the period. Pending writes are lost.
- `pwm_out` and `period_start` lag `cnt` by 1 cycle: the edge-aligned output rises one cycle after `cnt` becomes 0.
- The first `period_start` pulse comes 1 cycle after reset is released.
- A write is visible on `pwm_out` in the period after the next boundary edge: at most one full period + 1 cycle after the write.
- `ch_en`/`ch_inv` changes reach `pwm_out` 1 cycle later, with no period alignment.
- No combinational path from any input to any output.

## Test plan
All scenarios use N_CH=2, WIDTH=4 (MAX=15).
- Reset, then write ch0 D=4, edge mode, `ch_en`=11, `ch_inv`=00 -> for the first period ch0 is low. From the next period ch0 is high for 4 of every 16 cycles; `upd_pending[0]` is 1 until the boundary. ch1 stays low.
- Center mode, ch0 D=4 -> period of 30 cycles, ch0 high for 7 cycles, symmetric about `cnt`=0. `period_start` every 30 cycles.
- ch0 D=15 in edge mode -> high 15 of 16 cycles. D=0 -> always low. With `ch_inv[0]`=1 these become 1 low cycle per 16, and always high.
- Write D=8 on the exact boundary edge while the shadow holds 2 -> the following period uses 2 and `upd_pending` stays 1. The period after that uses 8.
- Toggle `mode` mid-period -> the current period completes unchanged, and the new mode starts at `cnt`=0. Write with `wr_addr`=3 -> no register changes.
- Assert `reset` mid-period with a pending write -> the next cycle has `pwm_out`=00 and `upd_pending`=00, and the counter restarts at 0.
